// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu; the sgn signal exists only when ALU_SIGNED_EN is defined.
// master = operand source / result sink, slave = the ALU.
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 flag_zero;
    logic                 flag_carry;
    logic                 flag_err;
`ifdef ALU_SIGNED_EN
    logic                 sgn;

    modport master (
        output in_valid, op, a, b, sgn, out_ready,
        input  in_ready, out_valid, result, flag_zero, flag_carry, flag_err
    );
    modport slave (
        input  in_valid, op, a, b, sgn, out_ready,
        output in_ready, out_valid, result, flag_zero, flag_carry, flag_err
    );
`else
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flag_zero, flag_carry, flag_err
    );
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flag_zero, flag_carry, flag_err
    );
`endif
endinterface

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle logic/add/sub, WIDTH-cycle shift-add multiply and restoring divide.
// Optional two's complement MUL/DIV and signed overflow flag when ALU_SIGNED_EN is defined.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_DIV = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;

    // IDLE: accept operands | BUSY: one MUL/DIV iteration per cycle | DONE: present result until taken
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH-1:0]     r_mag_b;
    logic                 r_is_mul;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_err_pend;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_zero;
    logic                 r_carry;
    logic                 r_err;

    logic                 w_sgn;
    logic                 w_accept;
    logic                 w_multi;
    logic                 w_min_neg1;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_add;
    logic [WIDTH:0]       w_sub;
    logic [2*WIDTH-1:0]   w_single_res;
    logic                 w_single_carry;
    logic                 w_single_err;
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_div_shift;
    logic                 w_div_ok;
    logic [WIDTH-1:0]     w_it_hi;
    logic [WIDTH-1:0]     w_it_lo;
    logic [2*WIDTH-1:0]   w_raw;
    logic [2*WIDTH-1:0]   w_fix;

`ifdef ALU_SIGNED_EN
    assign w_sgn = bus.sgn;
`else
    assign w_sgn = 1'b0;
`endif

    assign w_accept   = bus.in_valid && (r_state == S_IDLE);
    assign w_multi    = (bus.op == OP_MUL) || ((bus.op == OP_DIV) && (bus.b != '0));
    assign w_mag_a    = (w_sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign w_mag_b    = (w_sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign w_min_neg1 = w_sgn && (bus.op == OP_DIV) && (bus.b == '1)
                        && (bus.a == {1'b1, {(WIDTH-1){1'b0}}});

    always_comb begin
        w_add          = {1'b0, bus.a} + {1'b0, bus.b};
        w_sub          = {1'b0, bus.a} - {1'b0, bus.b};
        w_single_res   = '0;
        w_single_carry = 1'b0;
        w_single_err   = 1'b0;
        case (bus.op)
            OP_AND: w_single_res[WIDTH-1:0] = bus.a & bus.b;
            OP_OR:  w_single_res[WIDTH-1:0] = bus.a | bus.b;
            OP_XOR: w_single_res[WIDTH-1:0] = bus.a ^ bus.b;
            OP_ADD: begin
                w_single_res[WIDTH:0] = w_add;
                w_single_carry = w_sgn ? ((bus.a[WIDTH-1] == bus.b[WIDTH-1])
                                          && (w_add[WIDTH-1] != bus.a[WIDTH-1]))
                                       : w_add[WIDTH];
            end
            OP_SUB: begin
                w_single_res[WIDTH-1:0] = w_sub[WIDTH-1:0];
                w_single_carry = w_sgn ? ((bus.a[WIDTH-1] != bus.b[WIDTH-1])
                                          && (w_sub[WIDTH-1] != bus.a[WIDTH-1]))
                                       : w_sub[WIDTH];
            end
            // Only divide-by-zero reaches the single-cycle path for DIV.
            OP_DIV: begin
                w_single_res = {bus.a, {WIDTH{1'b1}}};
                w_single_err = 1'b1;
            end
            OP_MUL: ;
            default: w_single_err = 1'b1;
        endcase
    end

    // r_hi/r_lo hold {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mag_b} : '0);
        w_div_shift = {r_hi, r_lo[WIDTH-1]};
        w_div_ok    = (w_div_shift >= {1'b0, r_mag_b});
        if (r_is_mul) begin
            w_it_hi = w_mul_sum[WIDTH:1];
            w_it_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end else begin
            w_it_hi = w_div_ok ? WIDTH'(w_div_shift - {1'b0, r_mag_b}) : w_div_shift[WIDTH-1:0];
            w_it_lo = {r_lo[WIDTH-2:0], w_div_ok};
        end
        w_raw = {w_it_hi, w_it_lo};
        if (r_is_mul) begin
            w_fix = r_neg_q ? -w_raw : w_raw;
        end else begin
            w_fix = {(r_neg_r ? -w_it_hi : w_it_hi), (r_neg_q ? -w_it_lo : w_it_lo)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = w_multi ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_mag_b    <= '0;
            r_is_mul   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_err_pend <= 1'b0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_mul   <= (bus.op == OP_MUL);
                        r_neg_q    <= w_sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_neg_r    <= w_sgn && bus.a[WIDTH-1];
                        r_err_pend <= w_min_neg1;
                        r_hi       <= '0;
                        r_lo       <= w_mag_a;
                        r_mag_b    <= w_mag_b;
                        r_cnt      <= CNT_W'(WIDTH);
                        if (!w_multi) begin
                            r_result <= w_single_res;
                            r_zero   <= (w_single_res == '0);
                            r_carry  <= w_single_carry;
                            r_err    <= w_single_err;
                        end
                    end
                end
                S_BUSY: begin
                    r_hi  <= w_it_hi;
                    r_lo  <= w_it_lo;
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Last iteration: sign fix-up folds into the DONE-entry write.
                    if (r_cnt == CNT_W'(1)) begin
                        r_result <= w_fix;
                        r_zero   <= (w_fix == '0);
                        r_carry  <= 1'b0;
                        r_err    <= r_err_pend;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result     = r_result;
    assign bus.flag_zero  = r_zero;
    assign bus.flag_carry = r_carry;
    assign bus.flag_err   = r_err;
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed cases plus random ops against an integer reference model.
module tb_seq_alu;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus();

    seq_alu #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation definitions.
    function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic sgn, output logic [15:0] res, output logic carry,
                                  output logic err, output int lat);
        int ia, ib, sa, sb, t, q, r;
        ia = int'(a);
        ib = int'(b);
        sa = a[7] ? ia - 256 : ia;
        sb = b[7] ? ib - 256 : ib;
        res = '0; carry = 1'b0; err = 1'b0; lat = 1;
        case (op)
            3'd0: res = 16'(ia & ib);
            3'd1: res = 16'(ia | ib);
            3'd6: res = 16'(ia ^ ib);
            3'd2: begin
                t = ia + ib;
                res = 16'(t);
                carry = sgn ? ((sa + sb > 127) || (sa + sb < -128)) : (t > 255);
            end
            3'd3: begin
                res = 16'((ia - ib + 256) % 256);
                carry = sgn ? ((sa - sb > 127) || (sa - sb < -128)) : (ia < ib);
            end
            3'd4: begin
                lat = W + 1;
                t = sgn ? sa * sb : ia * ib;
                res = 16'(t);
            end
            3'd5: begin
                if (ib == 0) begin
                    res = {a, 8'hFF};
                    err = 1'b1;
                end else begin
                    lat = W + 1;
                    if (sgn && sa == -128 && sb == -1) begin
                        res = 16'h0080;
                        err = 1'b1;
                    end else begin
                        q = sgn ? sa / sb : ia / ib;
                        r = sgn ? sa % sb : ia % ib;
                        res = {8'(r), 8'(q)};
                    end
                end
            end
            default: err = 1'b1;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic sgn, input int hold, input string tag);
        logic [15:0] er;
        logic ec, ee;
        int el, lat;
        model(op, a, b, sgn, er, ec, ee, el);
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
`ifdef ALU_SIGNED_EN
        bus.sgn = sgn;
`endif
        bus.in_valid = 1'b1;
        chk({tag, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op = 3'($urandom);
        bus.a  = 8'($urandom);
        bus.b  = 8'($urandom);
`ifdef ALU_SIGNED_EN
        bus.sgn = 1'($urandom);
`endif
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat <= 40) begin
            chk({tag, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(el));
        chk({tag, ".result"}, 32'(bus.result), 32'(er));
        chk({tag, ".zero"}, 32'(bus.flag_zero), 32'(er == 16'd0));
        chk({tag, ".carry"}, 32'(bus.flag_carry), 32'(ec));
        chk({tag, ".err"}, 32'(bus.flag_err), 32'(ee));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, ".hold_result"}, 32'(bus.result), 32'(er));
            chk({tag, ".hold_carry"}, 32'(bus.flag_carry), 32'(ec));
            chk({tag, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        chk({tag, ".in_ready_xfer"}, 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, ".valid_after"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".in_ready_after"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int seen_valid;
        logic [2:0] rop;
        logic [7:0] ra, rb;
        logic rs;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op = '0;
        bus.a  = '0;
        bus.b  = '0;
`ifdef ALU_SIGNED_EN
        bus.sgn = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset.result", 32'(bus.result), 32'd0);
        chk("reset.zero", 32'(bus.flag_zero), 32'd0);
        chk("reset.carry", 32'(bus.flag_carry), 32'd0);
        chk("reset.err", 32'(bus.flag_err), 32'd0);
        rst = 1'b0;

        do_op(3'd2, 8'd200, 8'd100, 1'b0, 0, "add_200_100");
        do_op(3'd4, 8'd255, 8'd255, 1'b0, 0, "mul_255_255");
        do_op(3'd5, 8'd100, 8'd7,   1'b0, 0, "div_100_7");
        do_op(3'd5, 8'd5,   8'd0,   1'b0, 0, "div_by_zero");
        do_op(3'd3, 8'd3,   8'd5,   1'b0, 4, "sub_hold");
        do_op(3'd7, 8'hA5,  8'h5A,  1'b0, 1, "reserved");
        do_op(3'd3, 8'd9,   8'd9,   1'b0, 0, "sub_zero");
        do_op(3'd5, 8'd3,   8'd200, 1'b0, 0, "div_small");
        do_op(3'd4, 8'd0,   8'd77,  1'b0, 0, "mul_zero");

        // Abort a multiply partway through with reset.
        bus.op = 3'd4;
        bus.a  = 8'hAB;
        bus.b  = 8'h3C;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort.out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort.result", 32'(bus.result), 32'd0);
        chk("abort.in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort.err", 32'(bus.flag_err), 32'd0);
        seen_valid = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen_valid++;
        end
        chk("abort.no_result", 32'(seen_valid), 32'd0);
        do_op(3'd0, 8'hF0, 8'h0F, 1'b0, 0, "and_after_abort");

`ifdef ALU_SIGNED_EN
        do_op(3'd5, 8'hF9, 8'd2,   1'b1, 0, "sdiv_m7_2");
        do_op(3'd5, 8'h80, 8'hFF,  1'b1, 0, "sdiv_min_m1");
        do_op(3'd5, 8'h85, 8'd0,   1'b1, 0, "sdiv_zero");
        do_op(3'd4, 8'hFD, 8'd7,   1'b1, 0, "smul_m3_7");
        do_op(3'd2, 8'd100, 8'd100, 1'b1, 0, "sadd_ovf");
        do_op(3'd3, 8'h80, 8'd1,   1'b1, 0, "ssub_ovf");
`endif

        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            rs  = 1'b0;
`ifdef ALU_SIGNED_EN
            rs  = 1'($urandom);
`endif
            do_op(rop, ra, rb, rs, int'($urandom_range(0, 2)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
